mem_burst_ctrl: RTL and testbench

Parametrised single-port on-chip memory with valid/ready handshaking on three channels: request, write data and read data. Each request moves a burst of 1 to 2^LEN_WIDTH beats with byte-strobed writes and back-pressurable, full-throughput reads. Addresses wrap at DEPTH. It is the next-generation storage block for datapath buffers and register banks that need burst access and flow control.

---
 rtl/mem_burst_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst-access single-port memory with request, write-data and read-data handshakes.
// Reads are registered and back-pressurable; addresses wrap at DEPTH.
module mem_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    wstrb_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rlast_o,
  output logic                  wr_done_o
);

  localparam int NUM_BYTES = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [LEN_WIDTH-1:0]  beats_left_reg, beats_left_next;
  logic [WIDTH-1:0]      rdata_reg, rdata_next;
  logic                  rvalid_reg, rvalid_next;
  logic                  rlast_reg, rlast_next;
  logic                  wr_done_reg, wr_done_next;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] adv_addr;
  logic [WIDTH-1:0]      wmask;
  logic [WIDTH-1:0]      mem [DEPTH];

  // Out-of-range start addresses fold to word 0 rather than aliasing.
  assign start_addr = ({1'b0, addr_i} >= DEPTH_EXT) ? '0 : addr_i;
  assign adv_addr   = (cur_addr_reg == LAST_ADDR) ? '0 : cur_addr_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{wstrb_i[gi]}};
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    beats_left_next = beats_left_reg;
    rdata_next      = rdata_reg;
    rvalid_next     = rvalid_reg;
    rlast_next      = rlast_reg;
    wr_done_next    = 1'b0;
    wr_en           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          cur_addr_next   = start_addr;
          beats_left_next = len_i;
          if (wr_rd_en_i) begin
            state_next = WRITE;
          end else begin
            state_next  = READ;
            rdata_next  = mem[start_addr];
            rvalid_next = 1'b1;
            rlast_next  = (len_i == '0);
          end
        end
      end
      WRITE: begin
        if (wvalid_i) begin
          wr_en           = 1'b1;
          cur_addr_next   = adv_addr;
          beats_left_next = beats_left_reg - 1'b1;
          if (beats_left_reg == '0) begin
            state_next      = IDLE;
            beats_left_next = '0;
            wr_done_next    = 1'b1;
          end
        end
      end
      READ: begin
        // rdata/rlast only move on an accepted beat, so a stall holds them.
        if (rvalid_reg && rready_i) begin
          if (rlast_reg) begin
            state_next  = IDLE;
            rvalid_next = 1'b0;
            rlast_next  = 1'b0;
          end else begin
            rdata_next      = mem[adv_addr];
            cur_addr_next   = adv_addr;
            beats_left_next = beats_left_reg - 1'b1;
            rlast_next      = (beats_left_reg == LEN_WIDTH'(1));
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      cur_addr_reg   <= '0;
      beats_left_reg <= '0;
      rdata_reg      <= '0;
      rvalid_reg     <= 1'b0;
      rlast_reg      <= 1'b0;
      wr_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      beats_left_reg <= beats_left_next;
      rdata_reg      <= rdata_next;
      rvalid_reg     <= rvalid_next;
      rlast_reg      <= rlast_next;
      wr_done_reg    <= wr_done_next;
    end
  end

  // Reset clears the whole array, so storage is flops rather than block RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[cur_addr_reg] <= (mem[cur_addr_reg] & ~wmask) | (wdata_i & wmask);
    end
  end

  assign ready_o   = (state_reg == IDLE);
  assign wready_o  = (state_reg == WRITE);
  assign rvalid_o  = rvalid_reg;
  assign rlast_o   = rlast_reg;
  assign rdata_o   = rdata_reg;
  assign wr_done_o = wr_done_reg;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: directed table, corner sequences and
// randomized bursts checked against a word-array reference model.
module tb_mem_burst_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LW    = 3;

  typedef logic [15:0] word_q_t[$];
  typedef logic [1:0]  strb_q_t[$];

  typedef struct {
    bit               wr;
    int               addr;
    int               len;
    logic [3:0][15:0] data;  // write data, or expected read data
    logic [3:0][1:0]  strb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic          wr_rd_en_i;
  logic [AW-1:0] addr_i;
  logic [LW-1:0] len_i;
  logic          wvalid_i;
  logic          wready_o;
  logic [15:0]   wdata_i;
  logic [1:0]    wstrb_i;
  logic          rvalid_o;
  logic          rready_i;
  logic [15:0]   rdata_o;
  logic          rlast_o;
  logic          wr_done_o;

  always #5 clk = ~clk;

  mem_burst_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o), .wr_rd_en_i(wr_rd_en_i),
    .addr_i(addr_i), .len_i(len_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rlast_o(rlast_o),
    .wr_done_o(wr_done_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] model [DEPTH];
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_addr(input int a);
    return (a >= DEPTH) ? 0 : a;
  endfunction

  function automatic int next_addr(input int a);
    return (a == DEPTH - 1) ? 0 : a + 1;
  endfunction

  function automatic word_q_t model_exp(input int addr, input int len);
    word_q_t q;
    int a;
    a = first_addr(addr);
    for (int b = 0; b <= len; b++) begin
      q.push_back(model[a]);
      a = next_addr(a);
    end
    return q;
  endfunction

  // Ends in the cycle wr_done_o is expected high, so a following request tests read-after-write.
  task automatic do_write(input int addr, input int len, input word_q_t data,
                          input strb_q_t strb, input int gap_beat, input int gap_n);
    int a;
    $display("write addr=%0d len=%0d gap_beat=%0d gap_n=%0d", addr, len, gap_beat, gap_n);
    chk("wr_req_ready", 32'(ready_o), 32'(1));
    valid_i = 1'b1; wr_rd_en_i = 1'b1; addr_i = AW'(addr); len_i = LW'(len);
    step();
    valid_i = 1'b0;
    a = first_addr(addr);
    for (int b = 0; b <= len; b++) begin
      if (b == gap_beat) begin
        for (int k = 0; k < gap_n; k++) begin
          wvalid_i = 1'b0;
          chk("wready_gap", 32'(wready_o), 32'(1));
          step();
        end
      end
      wvalid_i = 1'b1; wdata_i = data[b]; wstrb_i = strb[b];
      chk("wready_beat", 32'(wready_o), 32'(1));
      chk("ready_in_write", 32'(ready_o), 32'(0));
      chk("wr_done_early", 32'(wr_done_o), 32'(0));
      step();
      for (int k = 0; k < 2; k++) begin
        if (strb[b][k]) model[a][8*k +: 8] = data[b][8*k +: 8];
      end
      a = next_addr(a);
    end
    wvalid_i = 1'b0;
    chk("wr_done_pulse", 32'(wr_done_o), 32'(1));
    chk("wr_end_ready", 32'(ready_o), 32'(1));
    chk("wr_end_wready", 32'(wready_o), 32'(0));
  endtask

  // noise: hold valid_i high (as a write request) and toggle wvalid_i while reading.
  task automatic do_read(input int addr, input int len, input word_q_t exp,
                         input int stall_beat, input int stall_n, input bit noise);
    $display("read  addr=%0d len=%0d stall_beat=%0d stall_n=%0d noise=%0d",
             addr, len, stall_beat, stall_n, noise);
    chk("rd_req_ready", 32'(ready_o), 32'(1));
    valid_i = 1'b1; wr_rd_en_i = 1'b0; addr_i = AW'(addr); len_i = LW'(len); rready_i = 1'b0;
    step();
    valid_i = noise; wr_rd_en_i = 1'b1;
    for (int b = 0; b <= len; b++) begin
      if (b == stall_beat) begin
        for (int k = 0; k < stall_n; k++) begin
          rready_i = 1'b0;
          wvalid_i = noise & k[0]; wdata_i = 16'($urandom); wstrb_i = 2'b11;
          chk("stall_rvalid", 32'(rvalid_o), 32'(1));
          chk("stall_rdata", 32'(rdata_o), 32'(exp[b]));
          chk("stall_rlast", 32'(rlast_o), 32'(b == len));
          step();
        end
      end
      rready_i = 1'b1;
      if (b == len) valid_i = 1'b0;
      wvalid_i = noise & ~b[0] & (b != len); wdata_i = 16'($urandom); wstrb_i = 2'b11;
      chk("rvalid", 32'(rvalid_o), 32'(1));
      chk("rdata", 32'(rdata_o), 32'(exp[b]));
      chk("rlast", 32'(rlast_o), 32'(b == len));
      chk("ready_in_read", 32'(ready_o), 32'(0));
      chk("wr_done_in_read", 32'(wr_done_o), 32'(0));
      step();
    end
    rready_i = 1'b0; valid_i = 1'b0; wvalid_i = 1'b0;
    chk("rd_end_rvalid", 32'(rvalid_o), 32'(0));
    chk("rd_end_rlast", 32'(rlast_o), 32'(0));
    chk("rd_end_ready", 32'(ready_o), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t dq;
    strb_q_t sq;
    int addr, len;

    tbl[0]  = '{wr: 0, addr: 0,  len: 3, data: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, strb: '0};
    tbl[1]  = '{wr: 1, addr: 5,  len: 1, data: {16'h0000, 16'h0000, 16'hABCD, 16'h1234},
                strb: {2'b00, 2'b00, 2'b01, 2'b11}};
    tbl[2]  = '{wr: 0, addr: 5,  len: 1, data: {16'h0000, 16'h0000, 16'h00CD, 16'h1234}, strb: '0};
    tbl[3]  = '{wr: 1, addr: 62, len: 3, data: {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                strb: {2'b11, 2'b11, 2'b11, 2'b11}};
    tbl[4]  = '{wr: 0, addr: 62, len: 3, data: {16'h0004, 16'h0003, 16'h0002, 16'h0001}, strb: '0};
    tbl[5]  = '{wr: 0, addr: 0,  len: 1, data: {16'h0000, 16'h0000, 16'h0004, 16'h0003}, strb: '0};
    tbl[6]  = '{wr: 0, addr: 4,  len: 2, data: {16'h0000, 16'h00CD, 16'h1234, 16'h0000}, strb: '0};
    tbl[7]  = '{wr: 1, addr: 5,  len: 0, data: {16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
                strb: {2'b00, 2'b00, 2'b00, 2'b00}};
    tbl[8]  = '{wr: 0, addr: 5,  len: 0, data: {16'h0000, 16'h0000, 16'h0000, 16'h1234}, strb: '0};
    tbl[9]  = '{wr: 1, addr: 6,  len: 0, data: {16'h0000, 16'h0000, 16'h0000, 16'h5A77},
                strb: {2'b00, 2'b00, 2'b00, 2'b10}};
    tbl[10] = '{wr: 0, addr: 6,  len: 0, data: {16'h0000, 16'h0000, 16'h0000, 16'h5ACD}, strb: '0};

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst_i = 1'b1; valid_i = 1'b0; wr_rd_en_i = 1'b0; addr_i = '0; len_i = '0;
    wvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; rready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'(1));
    chk("rst_wready", 32'(wready_o), 32'(0));
    chk("rst_rvalid", 32'(rvalid_o), 32'(0));
    chk("rst_rlast", 32'(rlast_o), 32'(0));
    chk("rst_rdata", 32'(rdata_o), 32'(0));
    chk("rst_wr_done", 32'(wr_done_o), 32'(0));

    // Directed table; writes are followed immediately by the next request.
    for (int i = 0; i < 11; i++) begin
      dq.delete(); sq.delete();
      for (int b = 0; b <= tbl[i].len; b++) begin
        dq.push_back(tbl[i].data[b]);
        sq.push_back(tbl[i].strb[b]);
      end
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].len, dq, sq, 1, (i == 3) ? 2 : 0);
      else           do_read(tbl[i].addr, tbl[i].len, dq, 0, 0, 1'b0);
    end

    // Stall of 3 cycles on beat 2 of a 4-beat read.
    dq = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
    sq = '{2'b11, 2'b11, 2'b11, 2'b11};
    do_write(20, 3, dq, sq, 0, 0);
    do_read(20, 3, dq, 1, 3, 1'b0);

    // Request and write-beat noise during a read must be ignored.
    dq = '{16'h7777, 16'h8888, 16'h9999, 16'hAAAA};
    do_write(30, 3, dq, sq, 0, 0);
    do_read(30, 3, model_exp(30, 3), 2, 2, 1'b1);
    do_read(30, 3, model_exp(30, 3), 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      addr = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        dq.delete(); sq.delete();
        for (int b = 0; b <= len; b++) begin
          dq.push_back(16'($urandom));
          sq.push_back(2'($urandom));
        end
        do_write(addr, len, dq, sq, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end else begin
        do_read(addr, len, model_exp(addr, len), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    // Reset midway through an 8-beat write abandons it and clears memory.
    $display("write addr=10 len=7 interrupted by reset after 4 beats");
    chk("rstmid_req_ready", 32'(ready_o), 32'(1));
    valid_i = 1'b1; wr_rd_en_i = 1'b1; addr_i = AW'(10); len_i = LW'(7);
    step();
    valid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wvalid_i = 1'b1; wdata_i = 16'($urandom) | 16'h0101; wstrb_i = 2'b11;
      step();
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; wvalid_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    chk("rstmid_ready", 32'(ready_o), 32'(1));
    chk("rstmid_wready", 32'(wready_o), 32'(0));
    chk("rstmid_rvalid", 32'(rvalid_o), 32'(0));
    chk("rstmid_rdata", 32'(rdata_o), 32'(0));
    chk("rstmid_wr_done", 32'(wr_done_o), 32'(0));
    dq = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_read(10, 7, dq, 0, 0, 1'b0);
    do_read(62, 3, model_exp(62, 3), 0, 0, 1'b0);
    do_read(20, 7, model_exp(20, 7), 3, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
